// File: rtl/googletest_hdl_pkg.sv
// Shared types for the objection tracker: FSM states, report severities
// and a 16-bit popcount helper.
package googletest_hdl_pkg;

    localparam int MAX_SRC = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        INFO  = 2'd0,
        WARN  = 2'd1,
        ERROR = 2'd2,
        FATAL = 2'd3
    } sev_t;

    function automatic logic [4:0] popcount16(input logic [MAX_SRC-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < MAX_SRC; i++) begin
            c = c + {4'b0000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/googletest_objection_tracker_if.sv
// Bundle of run-control, objection, report and status signals between a
// test environment (master) and the objection tracker (slave).
interface googletest_objection_tracker_if #(
    parameter int N_SRC = 4,
    parameter int CNT_W = 8
);
    logic             start;
    logic [N_SRC-1:0] raise;
    logic [N_SRC-1:0] drop;
    logic             rpt_valid;
    logic [1:0]       rpt_sev;
    logic             rpt_ready;
    logic [CNT_W-1:0] objections;
    logic             running;
    logic             done;
    logic             passed;
    logic             failed;
    logic [15:0]      num_warn;
    logic [15:0]      num_err;
    logic             ovf;

    modport master (
        output start, raise, drop, rpt_valid, rpt_sev,
        input  rpt_ready, objections, running, done, passed, failed,
               num_warn, num_err, ovf
    );

    modport slave (
        input  start, raise, drop, rpt_valid, rpt_sev,
        output rpt_ready, objections, running, done, passed, failed,
               num_warn, num_err, ovf
    );
endinterface

// File: rtl/googletest_objection_cnt.sv
// Saturating up/down objection counter: adds popcount(raise) and subtracts
// popcount(drop) each enabled cycle; ovf is sticky until clr.
module googletest_objection_cnt
    import googletest_hdl_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [N_SRC-1:0] raise,
    input  logic [N_SRC-1:0] drop,
    output logic [CNT_W-1:0] count,
    output logic             ovf,
    output logic             ovf_next
);

    // Six spare bits cover a 16-source swing in either direction plus sign.
    localparam int SUM_W = CNT_W + 6;
    localparam logic signed [SUM_W-1:0] CNT_MAX = {6'b000000, {CNT_W{1'b1}}};

    logic [MAX_SRC-1:0]      raise_ext;
    logic [MAX_SRC-1:0]      drop_ext;
    logic signed [SUM_W-1:0] sum;
    logic [CNT_W-1:0]        count_next;
    logic                    sat;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_SRC; gi++) begin : g_ext
            if (gi < N_SRC) begin : g_src
                assign raise_ext[gi] = raise[gi];
                assign drop_ext[gi]  = drop[gi];
            end else begin : g_pad
                assign raise_ext[gi] = 1'b0;
                assign drop_ext[gi]  = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        sum = $signed({6'b000000, count})
            + $signed({{(SUM_W-5){1'b0}}, popcount16(raise_ext)})
            - $signed({{(SUM_W-5){1'b0}}, popcount16(drop_ext)});
        sat        = 1'b0;
        count_next = sum[CNT_W-1:0];
        if (sum[SUM_W-1]) begin
            count_next = '0;
            sat        = 1'b1;
        end else if (sum > CNT_MAX) begin
            count_next = '1;
            sat        = 1'b1;
        end
        ovf_next = ovf;
        if (clr) begin
            ovf_next = 1'b0;
        end else if (en && sat) begin
            ovf_next = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            ovf <= ovf_next;
            if (clr) begin
                count <= '0;
            end else if (en) begin
                count <= count_next;
            end
        end
    end

endmodule

// File: rtl/googletest_objection_tracker.sv
// Test-run objection tracker: IDLE/INIT/RUN/DRAIN/DONE sequencing, report
// counting and pass/fail verdict. Optional watchdog: GOOGLETEST_HDL_WATCHDOG_EN.
module googletest_objection_tracker
    import googletest_hdl_pkg::*;
#(
    parameter int N_SRC        = 4,
    parameter int CNT_W        = 8,
    parameter int INIT_CYCLES  = 10,
    parameter int DRAIN_CYCLES = 16,
    parameter int WDOG_CYCLES  = 65535
) (
    input  logic                          clock,
    input  logic                          reset,
    googletest_objection_tracker_if.slave bus
);

    state_t      state_reg, state_next;
    logic [31:0] init_cnt_reg, init_cnt_next;
    logic [31:0] drain_cnt_reg, drain_cnt_next;
    logic [15:0] num_warn_reg, num_warn_next;
    logic [15:0] num_err_reg, num_err_next;
    logic        passed_reg, passed_next;
    logic        failed_reg, failed_next;

    logic [CNT_W-1:0] count;
    logic             ovf;
    logic             ovf_next;
    logic             accept;
    logic             fatal_hit;
    logic             cnt_en;
    logic             cnt_clr;
    logic             is_running;
    logic             zero;
    logic             wdog_hit;
    logic             timeout_next;
    logic             drain_one;

    assign is_running = (state_reg == RUN) || (state_reg == DRAIN);
    assign accept     = bus.rpt_valid && (state_reg != IDLE);
    assign fatal_hit  = accept && is_running && (sev_t'(bus.rpt_sev) == FATAL);
    assign cnt_en     = (state_reg == INIT) || is_running;
    assign cnt_clr    = bus.start && ((state_reg == IDLE) || (state_reg == DONE));
    assign zero       = (count == '0);
    // A single zero cycle already satisfies a drain length of 0 or 1.
    assign drain_one  = (32'd1 >= 32'(DRAIN_CYCLES));

    googletest_objection_cnt #(
        .N_SRC (N_SRC),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clock    (clock),
        .reset    (reset),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .raise    (bus.raise),
        .drop     (bus.drop),
        .count    (count),
        .ovf      (ovf),
        .ovf_next (ovf_next)
    );

`ifdef GOOGLETEST_HDL_WATCHDOG_EN
    logic [31:0] wdog_cnt_reg;
    logic        timeout_reg;

    assign wdog_hit     = is_running && (wdog_cnt_reg + 32'd1 >= 32'(WDOG_CYCLES));
    assign timeout_next = timeout_reg || wdog_hit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wdog_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else if (cnt_clr) begin
            wdog_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else if (is_running) begin
            if (wdog_hit) begin
                timeout_reg <= 1'b1;
            end else begin
                wdog_cnt_reg <= wdog_cnt_reg + 32'd1;
            end
        end
    end
`else
    assign wdog_hit     = 1'b0;
    assign timeout_next = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        init_cnt_next  = init_cnt_reg;
        drain_cnt_next = drain_cnt_reg;
        num_warn_next  = num_warn_reg;
        num_err_next   = num_err_reg;
        passed_next    = passed_reg;
        failed_next    = failed_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next    = INIT;
                    init_cnt_next = '0;
                end
            end
            INIT: begin
                if (init_cnt_reg + 32'd1 >= 32'(INIT_CYCLES)) begin
                    if (!zero) begin
                        state_next     = RUN;
                        drain_cnt_next = '0;
                    end else if (drain_one) begin
                        state_next = DONE;
                    end else begin
                        state_next     = DRAIN;
                        drain_cnt_next = 32'd1;
                    end
                end else begin
                    init_cnt_next = init_cnt_reg + 32'd1;
                end
            end
            RUN: begin
                if (fatal_hit || wdog_hit) begin
                    state_next = DONE;
                end else if (zero) begin
                    if (drain_one) begin
                        state_next = DONE;
                    end else begin
                        state_next     = DRAIN;
                        drain_cnt_next = 32'd1;
                    end
                end
            end
            DRAIN: begin
                if (fatal_hit || wdog_hit) begin
                    state_next = DONE;
                end else if (!zero) begin
                    state_next     = RUN;
                    drain_cnt_next = '0;
                end else if (drain_cnt_reg + 32'd1 >= 32'(DRAIN_CYCLES)) begin
                    state_next = DONE;
                end else begin
                    drain_cnt_next = drain_cnt_reg + 32'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (cnt_clr) begin
            num_warn_next = '0;
            num_err_next  = '0;
        end else if (accept) begin
            if ((sev_t'(bus.rpt_sev) == WARN) && (num_warn_reg != 16'hFFFF)) begin
                num_warn_next = num_warn_reg + 16'd1;
            end
            if ((sev_t'(bus.rpt_sev) == ERROR || sev_t'(bus.rpt_sev) == FATAL)
                && (num_err_reg != 16'hFFFF)) begin
                num_err_next = num_err_reg + 16'd1;
            end
        end

        // Verdict is frozen at DONE entry, using this cycle's report and overflow updates.
        if (state_next == DONE) begin
            if (state_reg != DONE) begin
                passed_next = (num_err_next == 16'd0) && !ovf_next && !timeout_next;
                failed_next = !passed_next;
            end
        end else begin
            passed_next = 1'b0;
            failed_next = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            init_cnt_reg  <= '0;
            drain_cnt_reg <= '0;
            num_warn_reg  <= '0;
            num_err_reg   <= '0;
            passed_reg    <= 1'b0;
            failed_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            init_cnt_reg  <= init_cnt_next;
            drain_cnt_reg <= drain_cnt_next;
            num_warn_reg  <= num_warn_next;
            num_err_reg   <= num_err_next;
            passed_reg    <= passed_next;
            failed_reg    <= failed_next;
        end
    end

    assign bus.rpt_ready  = (state_reg != IDLE);
    assign bus.objections = count;
    assign bus.running    = is_running;
    assign bus.done       = (state_reg == DONE);
    assign bus.passed     = passed_reg;
    assign bus.failed     = failed_reg;
    assign bus.num_warn   = num_warn_reg;
    assign bus.num_err    = num_err_reg;
    assign bus.ovf        = ovf;

endmodule
